// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: per-channel circular sample queues with whole-frame pop, underrun/overflow flags and watermark irq
module audio_frame_fifo #(
  parameter int CHANNELS = 2,
  parameter int DEPTH = 60,
  parameter int DATA_W = 24,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_in,
  input  logic                       wr_en_in,
  input  logic [CH_W-1:0]            wr_ch_in,
  input  logic [DATA_W-1:0]          wr_data_in,
  input  logic                       rd_req_in,
  output logic                       rd_valid_out,
  output logic [CHANNELS*DATA_W-1:0] rd_data_out,
  output logic                       underrun_out,
  output logic                       overflow_out,
  output logic [LVL_W-1:0]           level_out,
  input  logic [LVL_W-1:0]           watermark_in,
  output logic                       irq_out,
  input  logic                       irq_ack_in
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0] wr_ptr_q [CHANNELS], wr_ptr_d [CHANNELS];
  logic [PTR_W-1:0] rd_ptr_q [CHANNELS], rd_ptr_d [CHANNELS];
  logic [LVL_W-1:0] cnt_q [CHANNELS], cnt_d [CHANNELS];
  logic [DATA_W-1:0] mem [CHANNELS][DEPTH];
  logic [CHANNELS*DATA_W-1:0] rd_data_q, rd_data_d, heads;
  logic [LVL_W-1:0] level_q, level_d;
  logic rd_valid_q, rd_valid_d, underrun_q, underrun_d;
  logic overflow_q, overflow_d, irq_q, irq_d;
  logic pop_ok, ch_ok, wr_ok, do_wr, irq_set;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    pop_ok = rd_req_in && !clr_in;
    for (int k = 0; k < CHANNELS; k++) pop_ok = pop_ok && (cnt_q[k] != '0);
    ch_ok = 32'(wr_ch_in) < CHANNELS;
    // a full queue still takes a write when the same cycle pops a frame
    wr_ok = !clr_in && wr_en_in && ch_ok && (cnt_q[wr_ch_in] != LVL_W'(DEPTH) || pop_ok);
    level_d = LVL_W'(DEPTH);
    heads = '0;
    do_wr = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      do_wr = wr_ok && wr_ch_in == CH_W'(k);
      wr_ptr_d[k] = clr_in ? '0 : do_wr ? nxt(wr_ptr_q[k]) : wr_ptr_q[k];
      rd_ptr_d[k] = clr_in ? '0 : pop_ok ? nxt(rd_ptr_q[k]) : rd_ptr_q[k];
      cnt_d[k] = clr_in ? '0 : cnt_q[k] + LVL_W'(do_wr) - LVL_W'(pop_ok);
      heads[k*DATA_W +: DATA_W] = mem[k][rd_ptr_q[k]];
      level_d = cnt_d[k] < level_d ? cnt_d[k] : level_d;
    end
    rd_valid_d = !clr_in && rd_req_in;
    underrun_d = !clr_in && rd_req_in && !pop_ok;
    rd_data_d = clr_in ? '0 : pop_ok ? heads : rd_req_in ? '0 : rd_data_q;
    overflow_d = !clr_in && (overflow_q || (wr_en_in && ch_ok && !wr_ok));
    irq_set = pop_ok && level_q >= watermark_in && level_d < watermark_in;
    irq_d = !clr_in && (irq_set || (irq_q && !irq_ack_in));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      rd_data_q <= '0;
      level_q <= '0;
      rd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      level_q <= level_d;
      rd_valid_q <= rd_valid_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      irq_q <= irq_d;
    end
  end
  always_ff @(posedge clk) if (wr_ok) mem[wr_ch_in][wr_ptr_q[wr_ch_in]] <= wr_data_in;
  assign rd_valid_out = rd_valid_q;
  assign rd_data_out = rd_data_q;
  assign underrun_out = underrun_q;
  assign overflow_out = overflow_q;
  assign level_out = level_q;
  assign irq_out = irq_q;
endmodule

// File: tb/tb_audio_frame_fifo.sv
// tb_audio_frame_fifo: directed stimulus, expected frames queued at issue and checked by a monitor on rd_valid_out
module tb_audio_frame_fifo;
  logic clk = 0, rst = 1, clr_in = 0, wr_en_in = 0, rd_req_in = 0, irq_ack_in = 0;
  logic [0:0] wr_ch_in = '0;
  logic [23:0] wr_data_in = '0;
  logic rd_valid_out, underrun_out, overflow_out, irq_out;
  logic [47:0] rd_data_out;
  logic [5:0] level_out, watermark_in = '0;
  logic wr_en4 = 0, rd_req4 = 0, rd_valid4, underrun4, overflow4, irq4;
  logic [1:0] wr_ch4 = '0;
  logic [15:0] wr_data4 = '0;
  logic [63:0] rd_data4;
  logic [3:0] level4;
  int n_cmp = 0, n_bad = 0;
  logic [48:0] exp_q [$];
  logic [48:0] e;

  audio_frame_fifo dut (
    .clk(clk), .rst(rst), .clr_in(clr_in), .wr_en_in(wr_en_in), .wr_ch_in(wr_ch_in),
    .wr_data_in(wr_data_in), .rd_req_in(rd_req_in), .rd_valid_out(rd_valid_out),
    .rd_data_out(rd_data_out), .underrun_out(underrun_out), .overflow_out(overflow_out),
    .level_out(level_out), .watermark_in(watermark_in), .irq_out(irq_out), .irq_ack_in(irq_ack_in)
  );
  audio_frame_fifo #(.CHANNELS(4), .DEPTH(8), .DATA_W(16)) u4 (
    .clk(clk), .rst(rst), .clr_in(1'b0), .wr_en_in(wr_en4), .wr_ch_in(wr_ch4),
    .wr_data_in(wr_data4), .rd_req_in(rd_req4), .rd_valid_out(rd_valid4),
    .rd_data_out(rd_data4), .underrun_out(underrun4), .overflow_out(overflow4),
    .level_out(level4), .watermark_in(4'd0), .irq_out(irq4), .irq_ack_in(1'b0)
  );

  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end

  always @(negedge clk) if (!rst && rd_valid_out) begin
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_frame: got u=%b d=%h expected no frame", underrun_out, rd_data_out);
    end else begin
      e = exp_q.pop_front();
      if ({underrun_out, rd_data_out} !== e) begin
        n_bad++;
        $display("FAIL frame: got u=%b d=%h expected u=%b d=%h", underrun_out, rd_data_out, e[48], e[47:0]);
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    wr_en_in = 0;
    rd_req_in = 0;
    clr_in = 0;
    irq_ack_in = 0;
  endtask
  task automatic wr(input logic ch, input logic [23:0] d);
    wr_en_in = 1;
    wr_ch_in = ch;
    wr_data_in = d;
    step();
  endtask
  task automatic wrf(input logic [23:0] d0, input logic [23:0] d1);
    wr(1'b0, d0);
    wr(1'b1, d1);
  endtask
  task automatic pop(input logic [23:0] d1, input logic [23:0] d0, input logic u);
    rd_req_in = 1;
    exp_q.push_back({u, d1, d0});
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rd_valid_out, 0);
    chk("rst_under", underrun_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_irq", irq_out, 0);
    chk("rst_level", level_out, 0);
    chk("rst_data", rd_data_out, 0);
    rst = 0;
    step();
    // basic frame
    wrf(24'h000111, 24'h000222);
    chk("s1_level1", level_out, 1);
    pop(24'h000222, 24'h000111, 0);
    chk("s1_level0", level_out, 0);
    // underruns
    pop(0, 0, 1);
    chk("s2_level", level_out, 0);
    wr(1'b0, 24'h000333);
    pop(0, 0, 1);
    chk("s2_level_ch0only", level_out, 0);
    wr(1'b1, 24'h000444);
    chk("s2_level_after_ch1", level_out, 1);
    pop(24'h000444, 24'h000333, 0);
    // overflow and full write+pop
    for (int i = 0; i < 60; i++) wr(1'b0, 24'h1000 + 24'(i));
    chk("s3_no_ovf", overflow_out, 0);
    wr(1'b0, 24'h00DEAD);
    chk("s3_ovf", overflow_out, 1);
    for (int i = 0; i < 60; i++) wr(1'b1, 24'h2000 + 24'(i));
    chk("s3_level60", level_out, 60);
    wr_en_in = 1;
    wr_ch_in = 1'b0;
    wr_data_in = 24'h00BEEF;
    pop(24'h2000, 24'h1000, 0);
    chk("s3_level59", level_out, 59);
    for (int i = 1; i < 60; i++) pop(24'h2000 + 24'(i), 24'h1000 + 24'(i), 0);
    chk("s3_drained", level_out, 0);
    wr(1'b1, 24'h000005);
    pop(24'h000005, 24'h00BEEF, 0);
    chk("s3_ovf_sticky", overflow_out, 1);
    // wrap
    for (int i = 0; i < 200; i++) begin
      wrf(24'h100000 + 24'(i), 24'h200000 + 24'(i));
      pop(24'h200000 + 24'(i), 24'h100000 + 24'(i), 0);
    end
    chk("wrap_level", level_out, 0);
    // watermark irq
    watermark_in = 6'd4;
    for (int j = 0; j < 5; j++) wrf(24'h10 + 24'(j), 24'h20 + 24'(j));
    chk("irq_level5", level_out, 5);
    chk("irq_none_writes", irq_out, 0);
    pop(24'h20, 24'h10, 0);
    chk("irq_none_5to4", irq_out, 0);
    pop(24'h21, 24'h11, 0);
    chk("irq_set_4to3", irq_out, 1);
    wrf(24'h15, 24'h25);
    chk("irq_level4", level_out, 4);
    irq_ack_in = 1;
    pop(24'h22, 24'h12, 0);
    chk("irq_set_beats_ack", irq_out, 1);
    irq_ack_in = 1;
    step();
    chk("irq_ack", irq_out, 0);
    // clear
    watermark_in = 6'd3;
    pop(24'h23, 24'h13, 0);
    chk("clr_pre_irq", irq_out, 1);
    for (int j = 0; j < 8; j++) wrf(24'h30 + 24'(j), 24'h40 + 24'(j));
    chk("clr_pre_level", level_out, 10);
    chk("clr_pre_ovf", overflow_out, 1);
    clr_in = 1;
    wr_en_in = 1;
    wr_ch_in = 1'b0;
    wr_data_in = 24'h0000AA;
    rd_req_in = 1;
    irq_ack_in = 1;
    step();
    chk("clr_level", level_out, 0);
    chk("clr_ovf", overflow_out, 0);
    chk("clr_irq", irq_out, 0);
    chk("clr_valid", rd_valid_out, 0);
    chk("clr_data", rd_data_out, 0);
    pop(0, 0, 1);
    chk("clr_post_level", level_out, 0);
    // asynchronous reset mid-pop
    for (int j = 0; j < 7; j++) wrf(24'h50 + 24'(j), 24'h60 + 24'(j));
    pop(24'h60, 24'h50, 0);
    wrf(24'h57, 24'h67);
    chk("arst_pre_level", level_out, 7);
    rd_req_in = 1;
    #2;
    rst = 1;
    #1;
    chk("arst_level", level_out, 0);
    chk("arst_data", rd_data_out, 0);
    chk("arst_valid", rd_valid_out, 0);
    rd_req_in = 0;
    @(posedge clk);
    #1;
    rst = 0;
    step();
    step();
    chk("arst_no_valid", rd_valid_out, 0);
    pop(0, 0, 1);
    chk("arst_post_level", level_out, 0);
    // four-channel instance
    for (int c = 0; c < 4; c++) begin
      wr_en4 = 1;
      wr_ch4 = 2'(c);
      wr_data4 = 16'h1111 * 16'(c + 1);
      @(posedge clk);
      #1;
    end
    wr_en4 = 0;
    chk("c4_level1", level4, 1);
    rd_req4 = 1;
    @(posedge clk);
    #1;
    rd_req4 = 0;
    chk("c4_valid", rd_valid4, 1);
    chk("c4_data", rd_data4, 64'h4444_3333_2222_1111);
    chk("c4_under", underrun4, 0);
    chk("c4_level0", level4, 0);
    step();
    chk("c4_valid_pulse", rd_valid4, 0);
    chk("frames_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
